issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 50 +++++
 rtl/issue_ctrl_scoreboard.sv | 65 ++++++
 rtl/issue_ctrl.sv | 110 +++++++++++
 tb/tb_issue_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// Public_Info: shared types and constants for the issue stage.
//   PC_set        - decoded instruction payload carried through issue
//   INST_*_BIT    - inst_type one-hot class bit positions
//   LOAD_USE_LAT_DEF - default cycles a load's rd stays busy after issue
package Public_Info;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned REG_AW           = 5;
   localparam int unsigned NUM_REGS         = 32;
   localparam int unsigned INST_TYPE_W      = 10;
   localparam int unsigned BR_TYPE_W        = 4;

   localparam int unsigned INST_ALU_BIT     = 0;
   localparam int unsigned INST_MEM_BIT     = 1;
   localparam int unsigned INST_BR_BIT      = 2;
   localparam int unsigned INST_MUL_BIT     = 3;

   localparam int unsigned LOAD_USE_LAT_DEF = 2;

   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [XLEN-1:0]        inst;
      logic [INST_TYPE_W-1:0] inst_type;
      logic [BR_TYPE_W-1:0]   br_type;
      logic [REG_AW-1:0]      rf_raddr1;
      logic [REG_AW-1:0]      rf_raddr2;
      logic [REG_AW-1:0]      rf_rd;
      logic                   rf_we;
      logic                   mem_we;
      logic                   o_valid;
   } PC_set;

   // Idle payload: everything zero except the class field, which reads as a plain ALU op.
   function automatic PC_set pc_set_idle();
      PC_set s;
      s           = '0;
      s.inst_type = INST_TYPE_W'(1);
      return s;
   endfunction

   // Load = memory op that reads memory and writes a nonzero rd.
   function automatic logic is_load(input PC_set s);
      return s.inst_type[INST_MEM_BIT] && !s.mem_we && s.rf_we && (s.rf_rd != '0);
   endfunction

   function automatic logic is_branch(input PC_set s);
      return (s.br_type != '0) || s.inst_type[INST_BR_BIT];
   endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// issue_scoreboard: per-register load-use down-counters.
//   clk, rstn            - clock, async active-low reset
//   stall                - freezes all counters
//   set_en, set_addr     - a load issued this cycle; load its rd counter
//   qa_raddr1/2, qb_raddr1/2 - source queries for the two issue candidates
//   qa_busy1/2, qb_busy1/2   - combinational busy flags for those sources
module issue_scoreboard
   import Public_Info::*;
#(
   parameter int unsigned LOAD_USE_LAT = LOAD_USE_LAT_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              stall,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_addr,
   input  logic [REG_AW-1:0] qa_raddr1,
   input  logic [REG_AW-1:0] qa_raddr2,
   input  logic [REG_AW-1:0] qb_raddr1,
   input  logic [REG_AW-1:0] qb_raddr2,
   output logic              qa_busy1,
   output logic              qa_busy2,
   output logic              qb_busy1,
   output logic              qb_busy2
);

   localparam int unsigned CNT_W = (LOAD_USE_LAT < 1) ? 1 : $clog2(LOAD_USE_LAT + 1);

   logic [CNT_W-1:0] cnt_q [NUM_REGS];
   logic [CNT_W-1:0] cnt_d [NUM_REGS];

   // Decrement unless stalled; a same-edge set overrides the decrement. r0 stays 0.
   always_comb begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (!stall && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end
         if (set_en && (set_addr == REG_AW'(r))) begin
            cnt_d[r] = CNT_W'(LOAD_USE_LAT);
         end
         if (r == 0) begin
            cnt_d[r] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   assign qa_busy1 = (qa_raddr1 != '0) && (cnt_q[qa_raddr1] != '0);
   assign qa_busy2 = (qa_raddr2 != '0) && (cnt_q[qa_raddr2] != '0);
   assign qb_busy1 = (qb_raddr1 != '0) && (cnt_q[qb_raddr1] != '0);
   assign qb_busy2 = (qb_raddr2 != '0) && (cnt_q[qb_raddr2] != '0);

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue pairing and load-use interlock for the two oldest
// issue-buffer entries.
//   clk, rstn                - clock, async active-low reset
//   i_PC_set_a, i_PC_set_b   - buffer head and second-oldest entry
//   i_is_valid               - {a valid, b valid}
//   flush_BR                 - branch mispredict flush (highest priority)
//   stall_DCache             - back-end freeze
//   o_usingNUM               - entries consumed this cycle (combinational)
//   o_PC_set_a, o_PC_set_b   - registered lane A / lane B payloads
//   o_issue_valid            - registered {lane A valid, lane B valid}
module issue_ctrl
   import Public_Info::*;
#(
   parameter int unsigned LOAD_USE_LAT = LOAD_USE_LAT_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  PC_set       i_PC_set_a,
   input  PC_set       i_PC_set_b,
   input  logic [1:0]  i_is_valid,
   input  logic        flush_BR,
   input  logic        stall_DCache,
   output logic [1:0]  o_usingNUM,
   output PC_set       o_PC_set_a,
   output PC_set       o_PC_set_b,
   output logic [1:0]  o_issue_valid
);

   logic              a_busy1, a_busy2, b_busy1, b_busy2;
   logic              go;
   logic              issue_a, issue_b;
   logic              pair_raw, pair_struct, pair_shadow;
   logic              sb_set_en;
   logic [REG_AW-1:0] sb_set_addr;
   PC_set             lane_a_d, lane_b_d;

   issue_scoreboard #(
      .LOAD_USE_LAT (LOAD_USE_LAT)
   ) u_scoreboard (
      .clk       (clk),
      .rstn      (rstn),
      .stall     (stall_DCache),
      .set_en    (sb_set_en),
      .set_addr  (sb_set_addr),
      .qa_raddr1 (i_PC_set_a.rf_raddr1),
      .qa_raddr2 (i_PC_set_a.rf_raddr2),
      .qb_raddr1 (i_PC_set_b.rf_raddr1),
      .qb_raddr2 (i_PC_set_b.rf_raddr2),
      .qa_busy1  (a_busy1),
      .qa_busy2  (a_busy2),
      .qb_busy1  (b_busy1),
      .qb_busy2  (b_busy2)
   );

   // Issue decision; rstn gates it so nothing is consumed while in reset.
   always_comb begin
      go          = rstn && !flush_BR && !stall_DCache;
      issue_a     = go && i_is_valid[1] && !a_busy1 && !a_busy2;

      pair_raw    = i_PC_set_a.rf_we && (i_PC_set_a.rf_rd != '0) &&
                    ((i_PC_set_a.rf_rd == i_PC_set_b.rf_raddr1) ||
                     (i_PC_set_a.rf_rd == i_PC_set_b.rf_raddr2));
      pair_struct = (i_PC_set_a.inst_type[INST_MEM_BIT] && i_PC_set_b.inst_type[INST_MEM_BIT]) ||
                    (i_PC_set_a.inst_type[INST_BR_BIT]  && i_PC_set_b.inst_type[INST_BR_BIT])  ||
                    (i_PC_set_a.inst_type[INST_MUL_BIT] && i_PC_set_b.inst_type[INST_MUL_BIT]);
      pair_shadow = is_branch(i_PC_set_a);

      issue_b     = issue_a && i_is_valid[0] && !b_busy1 && !b_busy2 &&
                    !pair_raw && !pair_struct && !pair_shadow;

      o_usingNUM  = issue_b ? 2'd2 : (issue_a ? 2'd1 : 2'd0);
   end

   // At most one load issues per cycle (two mem ops never pair), so one set port suffices.
   always_comb begin
      sb_set_en   = 1'b0;
      sb_set_addr = i_PC_set_a.rf_rd;
      if (issue_a && is_load(i_PC_set_a)) begin
         sb_set_en   = 1'b1;
         sb_set_addr = i_PC_set_a.rf_rd;
      end else if (issue_b && is_load(i_PC_set_b)) begin
         sb_set_en   = 1'b1;
         sb_set_addr = i_PC_set_b.rf_rd;
      end
   end

   // Lane payloads carry their own valid bit in o_valid.
   always_comb begin
      lane_a_d         = i_PC_set_a;
      lane_a_d.o_valid = issue_a;
      lane_b_d         = i_PC_set_b;
      lane_b_d.o_valid = issue_b;
   end

   // Output registers: flush clears valids, stall holds, otherwise capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_issue_valid <= 2'b00;
         o_PC_set_a    <= pc_set_idle();
         o_PC_set_b    <= pc_set_idle();
      end else if (flush_BR) begin
         o_issue_valid <= 2'b00;
      end else if (!stall_DCache) begin
         o_issue_valid <= {issue_a, issue_b};
         o_PC_set_a    <= lane_a_d;
         o_PC_set_b    <= lane_b_d;
      end
   end

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
   import Public_Info::*;

   localparam int LAT = 2;

   logic       clk;
   logic       rstn;
   PC_set      i_PC_set_a, i_PC_set_b;
   logic [1:0] i_is_valid;
   logic       flush_BR, stall_DCache;
   logic [1:0] o_usingNUM;
   PC_set      o_PC_set_a, o_PC_set_b;
   logic [1:0] o_issue_valid;

   issue_ctrl #(.LOAD_USE_LAT(LAT)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_PC_set_a    (i_PC_set_a),
      .i_PC_set_b    (i_PC_set_b),
      .i_is_valid    (i_is_valid),
      .flush_BR      (flush_BR),
      .stall_DCache  (stall_DCache),
      .o_usingNUM    (o_usingNUM),
      .o_PC_set_a    (o_PC_set_a),
      .o_PC_set_b    (o_PC_set_b),
      .o_issue_valid (o_issue_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: remaining busy cycles per register and expected output lanes.
   int         busy_left [32];
   logic [1:0] exp_v;
   PC_set      exp_pa, exp_pb;

   function automatic bit reg_busy(input logic [4:0] r);
      return (r != 0) && (busy_left[r] > 0);
   endfunction

   function automatic bit ld(input PC_set s);
      return s.inst_type[INST_MEM_BIT] && !s.mem_we && s.rf_we && (s.rf_rd != 0);
   endfunction

   // Number of entries the issue rules allow this cycle.
   function automatic int model_take(input PC_set a, input PC_set b, input logic [1:0] v,
                                     input logic fl, input logic st);
      bit a_br, b_blocked;
      if (!rstn || fl || st || !v[1]) return 0;
      if (reg_busy(a.rf_raddr1) || reg_busy(a.rf_raddr2)) return 0;
      if (!v[0]) return 1;
      a_br      = a.inst_type[INST_BR_BIT] || (a.br_type != 0);
      b_blocked = reg_busy(b.rf_raddr1) || reg_busy(b.rf_raddr2) || a_br;
      if (a.rf_we && a.rf_rd != 0 && (a.rf_rd == b.rf_raddr1 || a.rf_rd == b.rf_raddr2))
         b_blocked = 1;
      for (int k = 1; k <= 3; k++)
         if (a.inst_type[k] && b.inst_type[k]) b_blocked = 1;
      return b_blocked ? 1 : 2;
   endfunction

   task automatic model_edge(input PC_set a, input PC_set b, input int n,
                             input logic fl, input logic st);
      if (fl) begin
         exp_v = 2'b00;
      end else if (!st) begin
         exp_v          = {n >= 1, n == 2};
         exp_pa         = a;
         exp_pa.o_valid = (n >= 1);
         exp_pb         = b;
         exp_pb.o_valid = (n == 2);
      end
      if (!st)
         for (int r = 0; r < 32; r++) if (busy_left[r] > 0) busy_left[r]--;
      if (n >= 1 && ld(a)) busy_left[a.rf_rd] = LAT;
      if (n == 2 && ld(b)) busy_left[b.rf_rd] = LAT;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) busy_left[r] = 0;
      exp_v  = 2'b00;
      exp_pa = pc_set_idle();
      exp_pb = pc_set_idle();
   endtask

   // One cycle: drive just after posedge, check o_usingNUM at negedge, check lanes after next posedge.
   task automatic step(input PC_set a, input PC_set b, input logic [1:0] v,
                       input logic fl, input logic st, output int num);
      int en;
      i_PC_set_a   = a;
      i_PC_set_b   = b;
      i_is_valid   = v;
      flush_BR     = fl;
      stall_DCache = st;
      @(negedge clk);
      en  = model_take(a, b, v, fl, st);
      num = int'(o_usingNUM);
      chk("usingNUM", 128'(o_usingNUM), 128'(en));
      @(posedge clk);
      model_edge(a, b, en, fl, st);
      #1;
      chk("issue_valid", 128'(o_issue_valid), 128'(exp_v));
      if (exp_v[1]) chk("lane_a", 128'(o_PC_set_a), 128'(exp_pa));
      if (exp_v[0]) chk("lane_b", 128'(o_PC_set_b), 128'(exp_pb));
   endtask

   function automatic PC_set mk(input int cls, input int rd, input int r1, input int r2,
                                input bit we, input bit mw);
      PC_set s;
      s           = '0;
      s.pc        = $urandom;
      s.inst      = $urandom;
      s.inst_type = INST_TYPE_W'(1) << cls;
      s.br_type   = (cls == INST_BR_BIT) ? 4'd1 : 4'd0;
      s.rf_rd     = 5'(rd);
      s.rf_raddr1 = 5'(r1);
      s.rf_raddr2 = 5'(r2);
      s.rf_we     = we;
      s.mem_we    = mw;
      return s;
   endfunction

   function automatic PC_set rand_inst();
      PC_set s;
      int cls;
      bit mw;
      cls = $urandom_range(0, 3);
      mw  = (cls == INST_MEM_BIT) ? 1'($urandom_range(0, 1)) : 1'b0;
      s   = mk(cls, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               (cls == INST_BR_BIT) ? 1'($urandom_range(0, 1)) : !mw, mw);
      if (cls == INST_ALU_BIT && $urandom_range(0, 9) == 0) s.br_type = 4'd2;
      return s;
   endfunction

   // Assert reset mid-cycle with a valid pair presented; release one cycle later.
   task automatic do_reset();
      rstn = 1'b0;
      #2;
      model_reset();
      chk("rst_valid", 128'(o_issue_valid), 128'(2'b00));
      chk("rst_lane_a", 128'(o_PC_set_a), 128'(pc_set_idle()));
      chk("rst_lane_b", 128'(o_PC_set_b), 128'(pc_set_idle()));
      chk("rst_num", 128'(o_usingNUM), 128'(2'd0));
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      PC_set nop, a, b, ldr4, add6;
      int n;
      rstn         = 1'b0;
      i_PC_set_a   = '0;
      i_PC_set_b   = '0;
      i_is_valid   = 2'b00;
      flush_BR     = 1'b0;
      stall_DCache = 1'b0;
      model_reset();
      nop  = mk(0, 0, 0, 0, 0, 0);
      ldr4 = mk(INST_MEM_BIT, 4, 1, 0, 1, 0);
      add6 = mk(0, 6, 4, 1, 1, 0);
      @(posedge clk);
      #1;
      i_PC_set_a = mk(0, 3, 1, 2, 1, 0);
      i_PC_set_b = mk(0, 5, 1, 2, 1, 0);
      i_is_valid = 2'b11;
      do_reset();

      // Pair RAW: b waits, then issues alone on lane A.
      a = mk(0, 3, 1, 2, 1, 0);
      b = mk(0, 5, 3, 4, 1, 0);
      step(a, b, 2'b11, 0, 0, n);
      chk("raw_num", 128'(n), 128'(1));
      chk("raw_v", 128'(o_issue_valid), 128'(2'b10));
      step(b, nop, 2'b10, 0, 0, n);
      chk("raw_b_num", 128'(n), 128'(1));
      chk("raw_b_rd", 128'(o_PC_set_a.rf_rd), 128'(5));

      // Load-use: dependent add blocked two cycles.
      step(ldr4, nop, 2'b10, 0, 0, n);
      chk("ld_num", 128'(n), 128'(1));
      step(add6, nop, 2'b10, 0, 0, n);
      chk("lu_blk1", 128'(n), 128'(0));
      step(add6, nop, 2'b10, 0, 0, n);
      chk("lu_blk2", 128'(n), 128'(0));
      step(add6, nop, 2'b10, 0, 0, n);
      chk("lu_go", 128'(n), 128'(1));

      // Structural mem pair, then independent pair.
      step(mk(INST_MEM_BIT, 7, 1, 2, 1, 0), mk(INST_MEM_BIT, 0, 3, 4, 0, 1), 2'b11, 0, 0, n);
      chk("mem_pair", 128'(n), 128'(1));
      step(mk(0, 8, 1, 2, 1, 0), mk(0, 9, 3, 2, 1, 0), 2'b11, 0, 0, n);
      chk("indep_num", 128'(n), 128'(2));
      chk("indep_v", 128'(o_issue_valid), 128'(2'b11));

      // Stall three cycles, then release.
      a = mk(0, 10, 1, 2, 1, 0);
      b = mk(0, 11, 3, 5, 1, 0);
      for (int k = 0; k < 3; k++) begin
         step(a, b, 2'b11, 0, 1, n);
         chk("stall_num", 128'(n), 128'(0));
         chk("stall_hold", 128'(o_issue_valid), 128'(2'b11));
      end
      step(a, b, 2'b11, 0, 0, n);
      chk("unstall_num", 128'(n), 128'(2));

      // Flush beats stall; scoreboard survives flush.
      step(ldr4, nop, 2'b10, 0, 0, n);
      step(a, b, 2'b11, 1, 1, n);
      chk("fl_num", 128'(n), 128'(0));
      chk("fl_v", 128'(o_issue_valid), 128'(2'b00));
      step(add6, nop, 2'b10, 0, 0, n);
      chk("fl_busy", 128'(n), 128'(0));

      // Reset clears in-flight load.
      step(ldr4, nop, 2'b10, 0, 0, n);
      do_reset();
      step(add6, nop, 2'b10, 0, 0, n);
      chk("rst_issue", 128'(n), 128'(1));
      chk("rst_issue_v", 128'(o_issue_valid), 128'(2'b10));

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         step(rand_inst(), rand_inst(), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), n);
         if (c == 300) begin
            i_is_valid = 2'b11;
            do_reset();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
